// File: rtl/deserializador_8_32.sv
// ---------------------------------------------------------------------------
// deserializador_8_32
// Byte-to-word reassembly stage placed after a 32->8 serializer. One byte is
// sampled per clk4f cycle while valid_in is high; four consecutive bytes form
// a 32-bit word, which is presented on data_out with a one-cycle valid_out
// pulse. A valid_in gap inside a word drops that word and pulses err_abort.
//
// Parameters
//   MSB_FIRST : 1 -> first byte of a word lands in [31:24]
//               0 -> first byte of a word lands in [7:0]
// Ports
//   clk4f     in   1   byte-rate clock, rising edge
//   reset_L   in   1   asynchronous reset, active low
//   valid_in  in   1   data_in holds a valid byte this cycle
//   data_in   in   8   byte from the serializer
//   valid_out out  1   one-cycle pulse, data_out holds a new word
//   data_out  out  32  last completed word (registered)
//   err_abort out  1   one-cycle pulse, a partial word was discarded
//   word_cnt  out  8   number of words emitted, wraps 255 -> 0
// ---------------------------------------------------------------------------
module deserializador_8_32 #(
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic        clk4f,
   input  logic        reset_L,
   input  logic        valid_in,
   input  logic [7:0]  data_in,
   output logic        valid_out,
   output logic [31:0] data_out,
   output logic        err_abort,
   output logic [7:0]  word_cnt
);

   typedef enum logic {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } state_t;

   state_t           state_reg;
   state_t           state_next;
   logic [1:0]       idx_reg;
   logic [1:0]       idx_next;
   // Bytes stored by arrival order; lane mapping is applied on the way out.
   logic [3:0][7:0]  byte_reg;
   // Set on the edge that samples the 4th byte; the word is published one
   // edge later, so valid_out rises on the edge after the 4th sample.
   logic             pend_reg;
   logic             capture;
   logic             complete;
   logic             abort;
   logic [31:0]      word_packed;

   // Arrival order -> output lane.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         localparam int POS = MSB_FIRST ? (3 - gi) : gi;
         assign word_packed[POS*8 +: 8] = byte_reg[gi];
      end
   endgenerate

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      capture    = 1'b0;
      complete   = 1'b0;
      abort      = 1'b0;
      unique case (state_reg)
         IDLE: begin
            idx_next = 2'd0;
            if (valid_in) begin
               capture    = 1'b1;
               idx_next   = 2'd1;
               state_next = COLLECT;
            end
         end
         COLLECT: begin
            if (valid_in) begin
               capture = 1'b1;
               if (idx_reg == 2'd3) begin
                  complete   = 1'b1;
                  idx_next   = 2'd0;
                  state_next = IDLE;
               end else begin
                  idx_next = idx_reg + 2'd1;
               end
            end else begin
               abort      = 1'b1;
               idx_next   = 2'd0;
               state_next = IDLE;
            end
         end
         default: begin
            idx_next   = 2'd0;
            state_next = IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk4f or negedge reset_L) begin
      if (!reset_L) begin
         state_reg <= IDLE;
         idx_reg   <= 2'd0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
      end
   end

   // Datapath and output registers. byte_reg is deliberately not cleared on
   // abort: every lane is rewritten before the next completion.
   always_ff @(posedge clk4f or negedge reset_L) begin
      if (!reset_L) begin
         byte_reg  <= '0;
         pend_reg  <= 1'b0;
         valid_out <= 1'b0;
         err_abort <= 1'b0;
         data_out  <= 32'h0;
         word_cnt  <= 8'h0;
      end else begin
         if (capture) begin
            byte_reg[idx_reg] <= data_in;
         end
         pend_reg  <= complete;
         err_abort <= abort;
         valid_out <= pend_reg;
         // byte_reg still holds the finished word here even if a new word's
         // first byte is captured on this same edge.
         if (pend_reg) begin
            data_out <= word_packed;
            word_cnt <= word_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_deserializador_8_32.sv
// ---------------------------------------------------------------------------
// tb_deserializador_8_32
// Directed self-checking bench. Two instances share the stimulus: one with
// MSB_FIRST=1 (dut_m) and one with MSB_FIRST=0 (dut_l). Inputs change 1 ns
// after the rising edge; outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_deserializador_8_32;

   logic        clk4f = 1'b0;
   logic        reset_L;
   logic        valid_in;
   logic [7:0]  data_in;

   logic        valid_out_m, err_abort_m;
   logic [31:0] data_out_m;
   logic [7:0]  word_cnt_m;
   logic        valid_out_l, err_abort_l;
   logic [31:0] data_out_l;
   logic [7:0]  word_cnt_l;

   int checks = 0;
   int errors = 0;

   always #5 clk4f = ~clk4f;

   deserializador_8_32 #(.MSB_FIRST(1'b1)) dut_m (
      .clk4f     (clk4f),
      .reset_L   (reset_L),
      .valid_in  (valid_in),
      .data_in   (data_in),
      .valid_out (valid_out_m),
      .data_out  (data_out_m),
      .err_abort (err_abort_m),
      .word_cnt  (word_cnt_m)
   );

   deserializador_8_32 #(.MSB_FIRST(1'b0)) dut_l (
      .clk4f     (clk4f),
      .reset_L   (reset_L),
      .valid_in  (valid_in),
      .data_in   (data_in),
      .valid_out (valid_out_l),
      .data_out  (data_out_l),
      .err_abort (err_abort_l),
      .word_cnt  (word_cnt_l)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Check the control outputs of both instances.
   task automatic chk_ctl(input string tag, input logic v, input logic e, input logic [7:0] c);
      chk({tag, " valid_out_m"}, {31'd0, valid_out_m}, {31'd0, v});
      chk({tag, " err_abort_m"}, {31'd0, err_abort_m}, {31'd0, e});
      chk({tag, " word_cnt_m"},  {24'd0, word_cnt_m},  {24'd0, c});
      chk({tag, " valid_out_l"}, {31'd0, valid_out_l}, {31'd0, v});
      chk({tag, " err_abort_l"}, {31'd0, err_abort_l}, {31'd0, e});
      chk({tag, " word_cnt_l"},  {24'd0, word_cnt_l},  {24'd0, c});
   endtask

   task automatic chk_data(input string tag, input logic [31:0] em, input logic [31:0] el);
      chk({tag, " data_out_m"}, data_out_m, em);
      chk({tag, " data_out_l"}, data_out_l, el);
   endtask

   task automatic step(input logic v, input logic [7:0] d);
      valid_in = v;
      data_in  = d;
      @(posedge clk4f);
      #1;
   endtask

   initial begin
      logic [7:0]  b0, b1, b2, b3;
      logic [31:0] exp_m, exp_l;
      int          pulses;
      int          pulses_l;

      // ---------------- reset then idle ----------------
      reset_L  = 1'b0;
      valid_in = 1'b0;
      data_in  = 8'h00;
      repeat (3) @(posedge clk4f);
      #1;
      chk_ctl("reset", 1'b0, 1'b0, 8'd0);
      chk_data("reset", 32'h0, 32'h0);
      reset_L = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 8'h5A);
         chk_ctl($sformatf("idle%0d", i), 1'b0, 1'b0, 8'd0);
      end
      chk_data("idle", 32'h0, 32'h0);

      // ---------------- single word FF x4 ----------------
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 8'hFF);
         chk_ctl($sformatf("ff_byte%0d", i), 1'b0, 1'b0, 8'd0);
      end
      step(1'b0, 8'h00);
      chk_ctl("ff_pulse", 1'b1, 1'b0, 8'd1);
      chk_data("ff_pulse", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      step(1'b0, 8'h00);
      chk_ctl("ff_after", 1'b0, 1'b0, 8'd1);

      // ---------------- back-to-back DDx4 then 00,00,00,03 ----------------
      for (int i = 0; i < 4; i++) step(1'b1, 8'hDD);
      chk_ctl("b2b_w0_done", 1'b0, 1'b0, 8'd1);
      step(1'b1, 8'h00);
      chk_ctl("b2b_pulse0", 1'b1, 1'b0, 8'd2);
      chk_data("b2b_pulse0", 32'hDDDD_DDDD, 32'hDDDD_DDDD);
      step(1'b1, 8'h00);
      chk_ctl("b2b_gap1", 1'b0, 1'b0, 8'd2);
      step(1'b1, 8'h00);
      chk_ctl("b2b_gap2", 1'b0, 1'b0, 8'd2);
      step(1'b1, 8'h03);
      chk_ctl("b2b_gap3", 1'b0, 1'b0, 8'd2);
      chk_data("b2b_hold", 32'hDDDD_DDDD, 32'hDDDD_DDDD);
      step(1'b0, 8'h00);
      chk_ctl("b2b_pulse1", 1'b1, 1'b0, 8'd3);
      chk_data("b2b_pulse1", 32'h0000_0003, 32'h0300_0000);
      step(1'b0, 8'h00);
      chk_ctl("b2b_after", 1'b0, 1'b0, 8'd3);

      // ---------------- abort then lane order ----------------
      step(1'b1, 8'h11);
      step(1'b1, 8'h22);
      step(1'b0, 8'h00);
      chk_ctl("abort_pulse", 1'b0, 1'b1, 8'd3);
      chk_data("abort_keep", 32'h0000_0003, 32'h0300_0000);
      step(1'b0, 8'h00);
      chk_ctl("abort_after", 1'b0, 1'b0, 8'd3);
      step(1'b1, 8'h01);
      step(1'b1, 8'h02);
      step(1'b1, 8'h03);
      step(1'b1, 8'h04);
      chk_ctl("lane_wait", 1'b0, 1'b0, 8'd3);
      step(1'b0, 8'h00);
      chk_ctl("lane_pulse", 1'b1, 1'b0, 8'd4);
      chk_data("lane_order", 32'h0102_0304, 32'h0403_0201);

      // Abort on the very last lane: three bytes then a gap.
      step(1'b1, 8'hAA);
      step(1'b1, 8'hBB);
      step(1'b1, 8'hCC);
      step(1'b0, 8'h00);
      chk_ctl("abort3_pulse", 1'b0, 1'b1, 8'd4);
      chk_data("abort3_keep", 32'h0102_0304, 32'h0403_0201);

      // ---------------- reset mid-word ----------------
      step(1'b1, 8'h77);
      step(1'b1, 8'h88);
      #2;
      reset_L = 1'b0;
      #1;
      chk_ctl("async_rst", 1'b0, 1'b0, 8'd0);
      chk_data("async_rst", 32'h0, 32'h0);
      valid_in = 1'b1;
      data_in  = 8'h99;
      @(posedge clk4f);
      #1;
      chk_ctl("rst_hold", 1'b0, 1'b0, 8'd0);
      reset_L = 1'b1;
      // Partial word must be gone: two more bytes must not complete a word.
      step(1'b1, 8'h99);
      step(1'b1, 8'h99);
      step(1'b0, 8'h00);
      chk_ctl("rst_partial_lost", 1'b0, 1'b1, 8'd0);
      step(1'b0, 8'h00);

      // ---------------- 256 back-to-back words, counter wrap ----------------
      pulses   = 0;
      pulses_l = 0;
      exp_m    = 32'h0;
      exp_l    = 32'h0;
      for (int w = 0; w < 256; w++) begin
         b0 = w[7:0];
         b1 = 8'hA5;
         b2 = ~w[7:0];
         b3 = 8'h3C ^ w[7:0];
         for (int k = 0; k < 4; k++) begin
            case (k)
               0:       step(1'b1, b0);
               1:       step(1'b1, b1);
               2:       step(1'b1, b2);
               default: step(1'b1, b3);
            endcase
            if (valid_out_m) begin
               pulses++;
               chk($sformatf("wrap_data_m w%0d", pulses - 1), data_out_m, exp_m);
            end
            if (valid_out_l) begin
               pulses_l++;
               chk($sformatf("wrap_data_l w%0d", pulses_l - 1), data_out_l, exp_l);
            end
         end
         exp_m = {b0, b1, b2, b3};
         exp_l = {b3, b2, b1, b0};
      end
      step(1'b0, 8'h00);
      if (valid_out_m) pulses++;
      if (valid_out_l) pulses_l++;
      chk("wrap_last_m", data_out_m, exp_m);
      chk("wrap_last_l", data_out_l, exp_l);
      chk("wrap_pulses_m", pulses, 256);
      chk("wrap_pulses_l", pulses_l, 256);
      chk_ctl("wrap_cnt", 1'b1, 1'b0, 8'd0);
      step(1'b0, 8'h00);
      chk_ctl("wrap_end", 1'b0, 1'b0, 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
